branch_resolve_ctrl: RTL

- Branch-control sequencer for the 5-stage core.
- Predicts branch direction at fetch from a direct-mapped table of 2-bit saturating counters.
- Resolves each conditional branch in EX from the branch comparator's 1-bit result and, on a mispredict, issues a registered PC redirect plus a multi-cycle flush of younger stages.
- Keeps saturating branch and mispredict performance counters.

---
 rtl/branch_resolve_ctrl.sv | 156 +++++++++++++++
 1 files changed

// File: rtl/branch_resolve_ctrl.sv
// ============================================================================
// branch_resolve_ctrl : 2-bit counter branch predictor, EX-stage resolve,
//                       registered PC redirect and multi-cycle pipe flush.
// Revision: 1.0
// ============================================================================
`default_nettype none

module branch_resolve_ctrl #(
    parameter int PC_W      = 32,
    parameter int IDX_W     = 4,
    parameter int FLUSH_CYC = 2,
    parameter int CNT_W     = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [PC_W-1:0]  if_pc,
    output logic             if_pred_taken,
    input  logic             ex_valid,
    input  logic [PC_W-1:0]  ex_pc,
    input  logic [3:0]       ex_branch_ctl,
    input  logic             ex_pred_taken,
    input  logic             ex_branch_out,
    input  logic [PC_W-1:0]  ex_target,
    output logic             redirect_valid,
    output logic [PC_W-1:0]  redirect_pc,
    output logic             flush_o,
    output logic [CNT_W-1:0] br_count,
    output logic [CNT_W-1:0] mispred_count
);

    localparam int ENTRIES = 1 << IDX_W;
    localparam int FC_W    = 3;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        FLUSH = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [1:0]       tbl_q [ENTRIES];
    logic [1:0]       tbl_d [ENTRIES];
    logic             redirect_valid_q, redirect_valid_d;
    logic [PC_W-1:0]  redirect_pc_q, redirect_pc_d;
    logic             flush_q, flush_d;
    logic [FC_W-1:0]  fcnt_q, fcnt_d;
    logic [CNT_W-1:0] br_count_q, br_count_d;
    logic [CNT_W-1:0] mispred_count_q, mispred_count_d;

    logic             is_branch;
    logic             resolve;
    logic             mispredict;
    logic [IDX_W-1:0] if_idx;
    logic [IDX_W-1:0] ex_idx;
    logic             unused_pc_bits;

    assign if_idx = if_pc[IDX_W+1:2];
    assign ex_idx = ex_pc[IDX_W+1:2];
    assign unused_pc_bits = ^{if_pc[1:0], if_pc[PC_W-1:IDX_W+2]};

    always_comb begin
        is_branch = 1'b0;
        case (ex_branch_ctl)
            4'b0111, 4'b1011, 4'b1100, 4'b1101: is_branch = 1'b1;
            default:                            is_branch = 1'b0;
        endcase
    end

    // Wrong-path instructions sitting in EX during FLUSH must not resolve.
    assign resolve    = ex_valid & is_branch & (state_q == IDLE);
    assign mispredict = resolve & (ex_branch_out != ex_pred_taken);

    // Read the registered table: a same-index update is seen next cycle.
    assign if_pred_taken = tbl_q[if_idx][1];

    always_comb begin
        tbl_d = tbl_q;
        if (resolve) begin
            if (ex_branch_out) begin
                if (tbl_q[ex_idx] != 2'b11) tbl_d[ex_idx] = tbl_q[ex_idx] + 2'b01;
            end else begin
                if (tbl_q[ex_idx] != 2'b00) tbl_d[ex_idx] = tbl_q[ex_idx] - 2'b01;
            end
        end
    end

    always_comb begin
        br_count_d      = br_count_q;
        mispred_count_d = mispred_count_q;
        if (resolve && (br_count_q != {CNT_W{1'b1}}))
            br_count_d = br_count_q + CNT_W'(1);
        if (mispredict && (mispred_count_q != {CNT_W{1'b1}}))
            mispred_count_d = mispred_count_q + CNT_W'(1);
    end

    always_comb begin
        state_d          = state_q;
        redirect_valid_d = 1'b0;
        redirect_pc_d    = redirect_pc_q;
        flush_d          = flush_q;
        fcnt_d           = fcnt_q;
        case (state_q)
            IDLE: begin
                if (mispredict) begin
                    state_d          = FLUSH;
                    redirect_valid_d = 1'b1;
                    redirect_pc_d    = ex_branch_out ? ex_target : (ex_pc + PC_W'(4));
                    flush_d          = 1'b1;
                    fcnt_d           = FC_W'(FLUSH_CYC - 1);
                end
            end
            FLUSH: begin
                if (fcnt_q != '0) begin
                    fcnt_d = fcnt_q - FC_W'(1);
                end else begin
                    flush_d = 1'b0;
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
                flush_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q          <= IDLE;
            redirect_valid_q <= 1'b0;
            redirect_pc_q    <= '0;
            flush_q          <= 1'b0;
            fcnt_q           <= '0;
            br_count_q       <= '0;
            mispred_count_q  <= '0;
            for (int i = 0; i < ENTRIES; i++) tbl_q[i] <= 2'b01;
        end else begin
            state_q          <= state_d;
            redirect_valid_q <= redirect_valid_d;
            redirect_pc_q    <= redirect_pc_d;
            flush_q          <= flush_d;
            fcnt_q           <= fcnt_d;
            br_count_q       <= br_count_d;
            mispred_count_q  <= mispred_count_d;
            for (int i = 0; i < ENTRIES; i++) tbl_q[i] <= tbl_d[i];
        end
    end

    assign redirect_valid = redirect_valid_q;
    assign redirect_pc    = redirect_pc_q;
    assign flush_o        = flush_q;
    assign br_count       = br_count_q;
    assign mispred_count  = mispred_count_q;

endmodule

`default_nettype wire
